// File: rtl/regex_stream_ctx_pkg.sv
// Shared constants and FSM encoding for the regex stream-context block.
package regex_stream_ctx_pkg;

  localparam int DEF_NUM_STREAMS = 64;
  localparam int DEF_SID_W       = 6;
  localparam int DEF_STATE_W     = 8;
  localparam int DEF_CNT_W       = 16;

  // Packet life cycle: wait for a start, restore the matcher, stream characters, save back.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_COMMIT = 2'd3
  } ctx_state_e;

endpackage

// File: rtl/regex_stream_ctx_if.sv
// Bundle of packet, character, matcher and counter-read signals around the context block.
//
// Handshake: pkt_start is a valid strobe that is consumed only in a cycle where
// ready=1; when ready=0 the request is dropped, not held, so the producer must
// keep pkt_start asserted until it sees ready=1. char_vld has no back-pressure:
// every char_vld in RUN is forwarded to the matcher in the same cycle, and eop
// is meaningful only together with char_vld.
interface regex_stream_ctx_if
  import regex_stream_ctx_pkg::*;
#(
  parameter int SID_W   = DEF_SID_W,
  parameter int STATE_W = DEF_STATE_W,
  parameter int CNT_W   = DEF_CNT_W
);
  logic               pkt_start;
  logic [SID_W-1:0]   pkt_sid;
  logic               pkt_enable;
  logic               char_vld;
  logic [7:0]         char_in;
  logic               eop;
  logic               clear_all;
  logic               ready;
  logic               m_load_vld;
  logic [STATE_W-1:0] m_state_load;
  logic               m_char_vld;
  logic [7:0]         m_char;
  logic [STATE_W-1:0] m_state_out;
  logic               m_accept;
  logic               fired;
  logic [SID_W-1:0]   cnt_rd_sid;
  logic [CNT_W-1:0]   cnt_rd_data;

  // Packet source, matcher model and counter reader sit on this side.
  modport master (
    output pkt_start, pkt_sid, pkt_enable, char_vld, char_in, eop, clear_all,
    output m_state_out, m_accept, cnt_rd_sid,
    input  ready, m_load_vld, m_state_load, m_char_vld, m_char, fired, cnt_rd_data
  );

  // The context block itself.
  modport slave (
    input  pkt_start, pkt_sid, pkt_enable, char_vld, char_in, eop, clear_all,
    input  m_state_out, m_accept, cnt_rd_sid,
    output ready, m_load_vld, m_state_load, m_char_vld, m_char, fired, cnt_rd_data
  );
endinterface

// File: rtl/regex_ctx_ram.sv
// Per-stream matcher state store: one synchronous read port, one write port, no reset.
module regex_ctx_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  // Write port; contents are only trusted behind the top-level valid bits.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read; holds its last value while rd_en_i is low.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/regex_stream_ctx.sv
// Saves and restores regex matcher state per stream across packets and counts matching packets.
module regex_stream_ctx
  import regex_stream_ctx_pkg::*;
#(
  parameter int NUM_STREAMS = DEF_NUM_STREAMS,
  parameter int SID_W       = DEF_SID_W,
  parameter int STATE_W     = DEF_STATE_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  regex_stream_ctx_if.slave  bus,
  output ctx_state_e         dbg_state_o
);
  ctx_state_e           state_q, state_d;
  logic [SID_W-1:0]     sid_q;
  logic                 en_q;
  logic                 fired_q, fired_d;
  logic [NUM_STREAMS-1:0] valid_q;
  logic [CNT_W-1:0]     cnt_q [NUM_STREAMS];
  logic [CNT_W-1:0]     cnt_rd_q;
  logic [CNT_W-1:0]     cnt_cur, cnt_nxt;
  logic [STATE_W-1:0]   ram_rd_data;
  logic                 in_idle, start_acc, clear_go, commit_wr, hit;

  assign in_idle   = (state_q == ST_IDLE);
  assign start_acc = in_idle && !bus.clear_all && bus.pkt_start;
  assign clear_go  = in_idle && bus.clear_all;
  assign commit_wr = (state_q == ST_COMMIT) && en_q;
  // The last character's accept arrives in COMMIT, so it is folded in here.
  assign hit       = fired_q || bus.m_accept;
  assign cnt_cur   = cnt_q[sid_q];
  assign cnt_nxt   = (hit && (cnt_cur != {CNT_W{1'b1}})) ? cnt_cur + CNT_W'(1) : cnt_cur;

  // The read address follows pkt_sid while idle so the saved state is ready in LOAD.
  regex_ctx_ram #(
    .DEPTH (NUM_STREAMS),
    .AW    (SID_W),
    .DW    (STATE_W)
  ) u_ctx_ram (
    .clk       (clk),
    .rd_en_i   (in_idle),
    .rd_addr_i (bus.pkt_sid),
    .rd_data_o (ram_rd_data),
    .wr_en_i   (commit_wr),
    .wr_addr_i (sid_q),
    .wr_data_i (bus.m_state_out)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_acc) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_RUN;
      ST_RUN:    if (bus.char_vld && bus.eop) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake, matcher restore and character pass-through.
  always_comb begin
    bus.ready        = in_idle && !bus.clear_all;
    bus.m_load_vld   = (state_q == ST_LOAD);
    bus.m_state_load = '0;
    if ((state_q == ST_LOAD) && valid_q[sid_q]) bus.m_state_load = ram_rd_data;
    bus.m_char_vld   = (state_q == ST_RUN) && bus.char_vld;
    bus.m_char       = (state_q == ST_RUN) ? bus.char_in : 8'h00;
  end

  // Sticky match flag: cleared by an accepted start, set by any accept while streaming.
  always_comb begin
    fired_d = fired_q;
    if (start_acc) fired_d = 1'b0;
    else if (((state_q == ST_RUN) || (state_q == ST_COMMIT)) && bus.m_accept) fired_d = 1'b1;
  end

  // Packet attributes and the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sid_q   <= '0;
      en_q    <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      fired_q <= fired_d;
      if (start_acc) begin
        sid_q <= bus.pkt_sid;
        en_q  <= bus.pkt_enable;
      end
    end
  end

  // Valid bits and hit counters: bulk clear in idle, single-entry update on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) cnt_q[i] <= '0;
    end else if (clear_go) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) cnt_q[i] <= '0;
    end else if (commit_wr) begin
      valid_q[sid_q] <= 1'b1;
      cnt_q[sid_q]   <= cnt_nxt;
    end
  end

  // Counter read port; a same-cycle commit is seen only on the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_rd_q <= '0;
    else     cnt_rd_q <= cnt_q[bus.cnt_rd_sid];
  end

  assign bus.fired       = fired_q;
  assign bus.cnt_rd_data = cnt_rd_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_regex_stream_ctx.sv
// Directed bench for regex_stream_ctx with a small reference model and an expected-value queue.
module tb_regex_stream_ctx;
  import regex_stream_ctx_pkg::*;

  localparam int NS  = 64;
  localparam int SW  = 6;
  localparam int STW = 8;
  localparam int CW  = 16;

  logic       clk = 1'b0;
  logic       rst;
  ctx_state_e dbg_state;

  regex_stream_ctx_if #(.SID_W(SW), .STATE_W(STW), .CNT_W(CW)) bus ();

  regex_stream_ctx #(
    .NUM_STREAMS (NS),
    .SID_W       (SW),
    .STATE_W     (STW),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [CW-1:0]  exp_q[$];
  logic [CW-1:0]  m_cnt   [NS];
  logic           m_valid [NS];
  logic [STW-1:0] m_ctx   [NS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    logic [CW-1:0] e;
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, obs, 32'(e));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_cnt[i]   = '0;
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    bus.pkt_start   = 1'b0;
    bus.pkt_sid     = '0;
    bus.pkt_enable  = 1'b0;
    bus.char_vld    = 1'b0;
    bus.char_in     = 8'h00;
    bus.eop         = 1'b0;
    bus.clear_all   = 1'b0;
    bus.m_state_out = '0;
    bus.m_accept    = 1'b0;
    bus.cnt_rd_sid  = '0;
  endtask

  // Read one counter; expected value queued at issue, compared a cycle later.
  task automatic read_cnt(input int sid);
    @(negedge clk);
    bus.cnt_rd_sid = SW'(sid);
    exp_q.push_back(m_cnt[sid]);
    @(negedge clk);
    #1 sb_pop("cnt_rd", bus.cnt_rd_data);
  endtask

  // One full packet of n chars; acc_idx = char whose accept fires (-1: none).
  task automatic run_pkt(input int sid, input bit en, input int n, input int acc_idx,
                         input logic [STW-1:0] sout, input bit clr_mid);
    logic [7:0] ch;
    @(negedge clk);
    bus.pkt_start  = 1'b1;
    bus.pkt_sid    = SW'(sid);
    bus.pkt_enable = en;
    exp_q.push_back(m_valid[sid] ? CW'(m_ctx[sid]) : CW'(0));
    #1 check("ready_start", bus.ready, 1);
    @(negedge clk);
    bus.pkt_start = 1'b0;
    // Characters during LOAD must be ignored, even with eop.
    bus.char_vld  = 1'b1;
    bus.eop       = 1'b1;
    #1;
    check("load_vld", bus.m_load_vld, 1);
    sb_pop("load_state", bus.m_state_load);
    check("fired_clr", bus.fired, 0);
    check("load_char_blk", bus.m_char_vld, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ch               = 8'h61 + 8'(i);
      bus.char_vld     = 1'b1;
      bus.char_in      = ch;
      bus.eop          = (i == n - 1);
      bus.m_state_out  = sout;
      bus.m_accept     = (i > 0) && (acc_idx == i - 1);
      bus.clear_all    = clr_mid && (i == 0);
      #1;
      check("st_run", dbg_state, ST_RUN);
      check("m_char_vld", bus.m_char_vld, 1);
      check("m_char", bus.m_char, ch);
      if (clr_mid && (i == 0)) check("ready_busy", bus.ready, 0);
    end
    @(negedge clk);
    bus.clear_all  = 1'b0;
    bus.char_vld   = 1'b0;
    bus.eop        = 1'b0;
    bus.m_accept   = (acc_idx == n - 1);
    bus.cnt_rd_sid = SW'(sid);
    exp_q.push_back(m_cnt[sid]);
    #1 check("st_commit", dbg_state, ST_COMMIT);
    @(negedge clk);
    bus.m_accept = 1'b0;
    #1;
    check("st_idle", dbg_state, ST_IDLE);
    check("fired", bus.fired, acc_idx >= 0);
    sb_pop("cnt_at_commit", bus.cnt_rd_data);
    if (en) begin
      m_valid[sid] = 1'b1;
      m_ctx[sid]   = sout;
      if ((acc_idx >= 0) && (m_cnt[sid] != {CW{1'b1}})) m_cnt[sid] = m_cnt[sid] + CW'(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    bus.char_vld = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_ready", bus.ready, 1);
    check("rst_fired", bus.fired, 0);
    check("rst_load_vld", bus.m_load_vld, 0);
    check("rst_char_vld", bus.m_char_vld, 0);
    check("rst_cnt_rd", bus.cnt_rd_data, 0);
    idle_inputs();
    rst = 1'b0;

    // New stream 5: "ab", accept on 'b', then restart restores 0x17.
    run_pkt(5, 1'b1, 2, 1, 8'h17, 1'b0);
    read_cnt(5);
    run_pkt(5, 1'b1, 1, -1, 8'h22, 1'b0);
    read_cnt(5);

    // Disabled packet on stream 3: fires but saves nothing.
    run_pkt(3, 1'b0, 2, 0, 8'h33, 1'b0);
    read_cnt(3);
    run_pkt(3, 1'b1, 1, -1, 8'h44, 1'b0);

    // Stream 7 to count 5; each commit reads the pre-update value.
    for (int i = 0; i < 5; i++) run_pkt(7, 1'b1, 1, 0, STW'(8'h70 + i), 1'b0);
    read_cnt(7);

    // Saturation at the top of the counter range.
    @(negedge clk);
    dut.cnt_q[9]  = 16'hFFFF;
    m_cnt[9]      = 16'hFFFF;
    dut.cnt_q[10] = 16'hFFFE;
    m_cnt[10]     = 16'hFFFE;
    read_cnt(9);
    run_pkt(9, 1'b1, 3, 2, 8'h99, 1'b0);
    read_cnt(9);
    run_pkt(10, 1'b1, 2, 0, 8'hA0, 1'b0);
    read_cnt(10);
    run_pkt(10, 1'b1, 2, 1, 8'hA1, 1'b0);
    read_cnt(10);

    // clear_all wins over a same-cycle start.
    @(negedge clk);
    bus.clear_all  = 1'b1;
    bus.pkt_start  = 1'b1;
    bus.pkt_sid    = SW'(5);
    bus.pkt_enable = 1'b1;
    #1 check("clr_ready", bus.ready, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("clr_drop_state", dbg_state, ST_IDLE);
    check("clr_drop_load", bus.m_load_vld, 0);
    model_reset();
    read_cnt(5);
    read_cnt(7);
    read_cnt(9);
    run_pkt(5, 1'b1, 1, 0, 8'h55, 1'b1);
    read_cnt(5);
    run_pkt(7, 1'b1, 1, -1, 8'h77, 1'b0);

    // Reset in the middle of a packet on stream 2.
    @(negedge clk);
    bus.pkt_start  = 1'b1;
    bus.pkt_sid    = SW'(2);
    bus.pkt_enable = 1'b1;
    @(negedge clk);
    bus.pkt_start  = 1'b0;
    @(negedge clk);
    bus.char_vld   = 1'b1;
    bus.char_in    = 8'h78;
    bus.m_state_out = 8'h2A;
    @(negedge clk);
    bus.m_accept   = 1'b1;
    #1 check("pre_rst_run", dbg_state, ST_RUN);
    @(negedge clk);
    bus.m_accept   = 1'b0;
    #1 check("pre_rst_fired", bus.fired, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_fired", bus.fired, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    model_reset();
    read_cnt(2);
    read_cnt(5);
    run_pkt(2, 1'b1, 1, -1, 8'h02, 1'b0);
    run_pkt(5, 1'b1, 1, -1, 8'h05, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
